// File: rtl/mod241_serial_reducer_if.sv
// Handshake bundle for mod241_serial_reducer.
// master: operand source / residue consumer side. slave: the reducer.
interface mod241_serial_reducer_if #(
    parameter int CHUNK_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_chunk;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_res;
    logic               out_err;
    logic               busy;

    modport master (
        output in_valid, in_chunk, in_last, out_ready,
        input  in_ready, out_valid, out_res, out_err, busy
    );

    modport slave (
        input  in_valid, in_chunk, in_last, out_ready,
        output in_ready, out_valid, out_res, out_err, busy
    );
endinterface

// File: rtl/mod241_serial_reducer.sv
// Serial modular reducer: consumes an operand MSB-first in CHUNK_W-bit beats
// and returns operand mod MODULUS using Horner's rule, one beat per cycle.
// Optional length check: define MOD241_LEN_CHECK_EN to limit operands to
// MAX_CHUNKS beats; longer operands are drained and flagged with out_err.
module mod241_serial_reducer #(
    parameter int MODULUS    = 241,
    parameter int CHUNK_W    = 6,
    parameter int MAX_CHUNKS = 84
) (
    input  logic                  clk,
    input  logic                  rst,
    mod241_serial_reducer_if.slave bus
);
    localparam int SUM_W = 8 + CHUNK_W;

    // Elaboration-time guard on the parameter ranges the datapath assumes.
    if (MODULUS < 2 || MODULUS > 255 || MAX_CHUNKS < 1 || CHUNK_W < 1) begin : g_param_check
        $error("mod241_serial_reducer: illegal parameter value");
    end

`ifdef MOD241_LEN_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           r_state;
    logic [7:0]       r_acc;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [SUM_W-1:0] w_sum;
    logic [7:0]       w_next;
    logic             w_in_fire;
    logic             w_out_fire;

    // acc*2^CHUNK_W + chunk is a plain concatenation; full SUM_W width keeps
    // the largest intermediate exact before the modulo.
    assign w_sum      = {r_acc, bus.in_chunk};
    assign w_next     = 8'(w_sum % SUM_W'(MODULUS));
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

`ifdef MOD241_LEN_CHECK_EN
    localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit_max;
    logic             r_err;

    // First beat of an operand always counts as one, regardless of stale cnt.
    assign w_cnt_inc = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_hit_max = (w_cnt_inc == CNT_W'(MAX_CHUNKS));
    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_acc;
    assign bus.busy      = r_busy;

    // Sequencer: accumulate beats, present the residue, wait for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MOD241_LEN_CHECK_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_in_fire) begin
                        r_acc  <= w_next;
                        r_busy <= 1'b1;
`ifdef MOD241_LEN_CHECK_EN
                        r_cnt  <= w_cnt_inc;
`endif
                        if (bus.in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
`ifdef MOD241_LEN_CHECK_EN
                        end else if (w_hit_max) begin
                            r_state <= S_DRAIN;
`endif
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
`ifdef MOD241_LEN_CHECK_EN
                S_DRAIN: begin
                    // acc and cnt stay frozen; beats are swallowed until the last one.
                    if (w_in_fire && bus.in_last) begin
                        r_state     <= S_DONE;
                        r_err       <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (w_out_fire) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
`ifdef MOD241_LEN_CHECK_EN
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod241_serial_reducer.sv
// Self-checking bench for mod241_serial_reducer. Honours MOD241_LEN_CHECK_EN
// (the length-checked build is instantiated with MAX_CHUNKS=4).
module tb_mod241_serial_reducer;
    localparam int M      = 241;
    localparam int CW     = 6;
    localparam int TB_MAX = 4;
`ifdef MOD241_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mod241_serial_reducer_if #(.CHUNK_W(CW)) ifc ();

    mod241_serial_reducer #(
        .MODULUS   (M),
        .CHUNK_W   (CW),
        .MAX_CHUNKS(TB_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    // Reference: operand value = sum(c_i * 64^(n-1-i)); reduce term by term
    // using powers of 64 mod M, from the least-significant beat upward.
    function automatic void model(input int beats[$], output int res, output bit err);
        int n = beats.size();
        int w = 1;
        int r = 0;
        err = 1'b0;
        if (LEN_CHK && n > TB_MAX) begin
            err = 1'b1;
            n   = TB_MAX;
        end
        for (int i = n - 1; i >= 0; i--) begin
            r = (r + beats[i] * w) % M;
            w = (w * (1 << CW)) % M;
        end
        res = r;
    endfunction

    task automatic put_beat(input int c, input bit last);
        bit ok = 1'b0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_chunk = CW'(c);
        ifc.in_last  = last;
        for (int k = 0; k < 50; k++) begin
            if (ifc.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 ifc.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout got=in_ready_low exp=accept");
        end
    endtask

    task automatic send_op(input int beats[$], input int max_gap);
        for (int i = 0; i < beats.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            put_beat(beats[i], i == beats.size() - 1);
        end
    endtask

    task automatic get_result(input int hold, output int res, output bit err);
        bit ok = 1'b0;
        res = -1;
        err = 1'b0;
        ifc.out_ready = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL result_timeout got=out_valid_low exp=out_valid_high");
            return;
        end
        repeat (hold) @(negedge clk);
        res = int'(ifc.out_res);
        err = ifc.out_err;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_chunk  = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.out_res !== 8'd0) begin bad++; $display("FAIL reset_out_res got=%0d exp=0", ifc.out_res); end
        total++; if (ifc.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", ifc.out_err); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        put_beat(63, 1'b1);
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", ifc.out_valid); end
        total++; if (ifc.out_res !== 8'd63) begin bad++; $display("FAIL single_res got=%0d exp=63", ifc.out_res); end
        total++; if (ifc.out_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", ifc.out_err); end
        total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", ifc.busy); end
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL single_done_ready got=%b exp=0", ifc.in_ready); end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL single_idle_ready got=%b exp=1", ifc.in_ready); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", ifc.busy); end
    endtask

    task automatic test_multi_beat();
        int res;
        bit err;
        send_op('{1, 0}, 0);
        get_result(0, res, err);
        total++; if (res !== 64) begin bad++; $display("FAIL multi_64 got=%0d exp=64", res); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL multi_64_err got=%b exp=0", err); end
        send_op('{3, 49}, 1);
        get_result(1, res, err);
        total++; if (res !== 0) begin bad++; $display("FAIL multi_241 got=%0d exp=0", res); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL multi_241_err got=%b exp=0", err); end
    endtask

    task automatic test_back_to_back();
        int  chunks[5] = '{63, 63, 63, 1, 0};
        bit  lasts[5]  = '{0, 0, 1, 0, 1};
        int  got[2]    = '{-1, -1};
        int  idx   = 0;
        int  nres  = 0;
        int  stall = 0;
        bit  fire;
        ifc.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
            @(negedge clk);
            fire = 1'b0;
            if (idx < 5) begin
                ifc.in_valid = 1'b1;
                ifc.in_chunk = CW'(chunks[idx]);
                ifc.in_last  = lasts[idx];
                if (ifc.in_ready) fire = 1'b1;
                else stall++;
            end else begin
                ifc.in_valid = 1'b0;
            end
            if (ifc.out_valid) begin
                got[nres] = int'(ifc.out_res);
                nres++;
            end
            @(posedge clk);
            if (fire) idx++;
        end
        #1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        total++; if (nres !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", nres); end
        total++; if (got[0] !== 176) begin bad++; $display("FAIL b2b_res0 got=%0d exp=176", got[0]); end
        total++; if (got[1] !== 64) begin bad++; $display("FAIL b2b_res1 got=%0d exp=64", got[1]); end
        total++; if (stall !== 1) begin bad++; $display("FAIL b2b_bubble got=%0d exp=1", stall); end
    endtask

    task automatic test_backpressure();
        int res;
        bit err;
        send_op('{63, 63, 63}, 0);
        ifc.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_chunk = CW'(7);
            ifc.in_last  = 1'b1;
            total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, ifc.out_valid); end
            total++; if (ifc.out_res !== 8'd176) begin bad++; $display("FAIL bp_res c=%0d got=%0d exp=176", c, ifc.out_res); end
            total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, ifc.in_ready); end
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        // the beat held during the stall is taken once the block is idle again
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b exp=1", ifc.in_ready); end
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        get_result(0, res, err);
        total++; if (res !== 7) begin bad++; $display("FAIL bp_pending_beat got=%0d exp=7", res); end
    endtask

    task automatic test_reset_mid();
        int res;
        bit err;
        put_beat(9, 1'b0);
        put_beat(10, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", ifc.busy); end
        total++; if (ifc.out_res !== 8'd0) begin bad++; $display("FAIL rstmid_res got=%0d exp=0", ifc.out_res); end
        send_op('{5}, 0);
        get_result(0, res, err);
        total++; if (res !== 5) begin bad++; $display("FAIL rstmid_after got=%0d exp=5", res); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_after_err got=%b exp=0", err); end
    endtask

    task automatic test_length();
        int q[$] = '{1, 1, 1, 1, 1, 1};
        int res, exp_res;
        bit err, exp_err;
        model(q, exp_res, exp_err);
        send_op(q, 0);
        get_result(2, res, err);
        total++; if (res !== exp_res) begin bad++; $display("FAIL length_res got=%0d exp=%0d", res, exp_res); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL length_err got=%b exp=%b", err, exp_err); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int q[$];
            int res, exp_res;
            bit err, exp_err;
            int n = $urandom_range(9, 1);
            for (int i = 0; i < n; i++) q.push_back($urandom_range(63, 0));
            model(q, exp_res, exp_err);
            send_op(q, 2);
            get_result($urandom_range(3, 0), res, err);
            total++; if (res !== exp_res) begin bad++; $display("FAIL random_res t=%0d n=%0d got=%0d exp=%0d", t, n, res, exp_res); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL random_err t=%0d n=%0d got=%b exp=%b", t, n, err, exp_err); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_length();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
